// File: rtl/pe_os_acc.sv
// ---------------------------------------------------------------------------
// pe_os_acc: output-stationary systolic-array processing element.
//
// Multiply-accumulates a signed row operand (a) and column operand (b) when
// both are valid, forwards operands to neighbours one cycle later, and exposes
// its accumulator through a vertical drain shift chain so one tile can be
// unloaded while the next accumulates.
//
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   a_in/a_valid_in           row operand and valid   -> a_out/a_valid_out
//   b_in/b_valid_in           column operand and valid -> b_out/b_valid_out
//   clr_in                    start of new tile        -> clr_out
//   load_in                   capture accumulator into the drain register
//   drain_in/drain_valid_in   drain chain from upstream PE
//   drain_out/drain_valid_out drain register to downstream PE
//   acc_out                   live accumulator
//   ovf                       sticky overflow since last clear
//   mac_cnt                   MACs since last clear, saturating
//   state                     tile FSM: IDLE=0, ACCUM=1, DONE=2
// ---------------------------------------------------------------------------
module pe_os_acc #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + 4,
    parameter bit          SATURATE   = 1'b1,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic                  a_valid_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    input  logic                  b_valid_in,
    input  logic                  clr_in,
    input  logic                  load_in,
    input  logic [ACC_WIDTH-1:0]  drain_in,
    input  logic                  drain_valid_in,
    output logic [DATA_WIDTH-1:0] a_out,
    output logic                  a_valid_out,
    output logic [DATA_WIDTH-1:0] b_out,
    output logic                  b_valid_out,
    output logic                  clr_out,
    output logic [ACC_WIDTH-1:0]  drain_out,
    output logic                  drain_valid_out,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  ovf,
    output logic [CNT_WIDTH-1:0]  mac_cnt,
    output logic [1:0]            state
);

    localparam int unsigned ProdW = 2 * DATA_WIDTH;
    localparam int unsigned ExtW  = ACC_WIDTH + 1 - ProdW;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StAccum = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e r_state, w_state_d;

    logic [DATA_WIDTH-1:0] r_a, r_b;
    logic                  r_a_v, r_b_v, r_clr;
    logic [ACC_WIDTH-1:0]  r_acc, r_drain;
    logic                  r_drain_v, r_ovf;
    logic [CNT_WIDTH-1:0]  r_cnt;

    logic                  w_fire;
    logic [ProdW-1:0]      w_a_ext, w_b_ext, w_prod;
    logic [ACC_WIDTH:0]    w_prod_ext, w_base, w_sum;
    logic                  w_ovf;
    logic [ACC_WIDTH-1:0]  w_acc_new;
    logic [CNT_WIDTH-1:0]  w_cnt_inc;

    assign w_fire = a_valid_in & b_valid_in;

    // Operands sign-extended to the product width; the low ProdW bits of an
    // unsigned multiply are then the exact two's-complement signed product.
    assign w_a_ext = {{DATA_WIDTH{a_in[DATA_WIDTH-1]}}, a_in};
    assign w_b_ext = {{DATA_WIDTH{b_in[DATA_WIDTH-1]}}, b_in};
    assign w_prod  = w_a_ext * w_b_ext;

    // One guard bit above the accumulator exposes overflow as a sign mismatch.
    assign w_prod_ext = {{ExtW{w_prod[ProdW-1]}}, w_prod};
    assign w_base     = clr_in ? '0 : {r_acc[ACC_WIDTH-1], r_acc};
    assign w_sum      = w_base + w_prod_ext;
    assign w_ovf      = w_sum[ACC_WIDTH] ^ w_sum[ACC_WIDTH-1];

    always_comb begin
        w_acc_new = w_sum[ACC_WIDTH-1:0];
        if (SATURATE && w_ovf) begin
            w_acc_new = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                         : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_WIDTH'(1);

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_a       <= '0;
            r_b       <= '0;
            r_a_v     <= 1'b0;
            r_b_v     <= 1'b0;
            r_clr     <= 1'b0;
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= '0;
            r_drain   <= '0;
            r_drain_v <= 1'b0;
        end else begin
            r_a   <= a_in;
            r_b   <= b_in;
            r_a_v <= a_valid_in;
            r_b_v <= b_valid_in;
            r_clr <= clr_in;

            if (w_fire) begin
                r_acc <= w_acc_new;
                r_ovf <= clr_in ? w_ovf : (r_ovf | w_ovf);
                r_cnt <= clr_in ? CNT_WIDTH'(1) : w_cnt_inc;
            end else if (clr_in) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
                r_cnt <= '0;
            end

            // Load takes the pre-update accumulator and drops upstream data.
            if (load_in) begin
                r_drain   <= r_acc;
                r_drain_v <= 1'b1;
            end else begin
                r_drain   <= drain_in;
                r_drain_v <= drain_valid_in;
            end
        end
    end

    // Tile FSM state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    // Fire and clear outrank load when choosing the next state.
    always_comb begin
        w_state_d = r_state;
        if (clr_in) begin
            w_state_d = w_fire ? StAccum : StIdle;
        end else if (w_fire) begin
            w_state_d = StAccum;
        end else if (load_in) begin
            w_state_d = StDone;
        end
    end

    assign a_out           = r_a;
    assign a_valid_out     = r_a_v;
    assign b_out           = r_b;
    assign b_valid_out     = r_b_v;
    assign clr_out         = r_clr;
    assign drain_out       = r_drain;
    assign drain_valid_out = r_drain_v;
    assign acc_out         = r_acc;
    assign ovf             = r_ovf;
    assign mac_cnt         = r_cnt;
    assign state           = r_state;

endmodule

// File: tb/tb_pe_os_acc.sv
// ---------------------------------------------------------------------------
// tb_pe_os_acc: directed bench for pe_os_acc. Two instances share inputs:
// u_sat (ACC_WIDTH=20, SATURATE=1) and u_wrp (ACC_WIDTH=20, SATURATE=0).
// ---------------------------------------------------------------------------
module tb_pe_os_acc;

    localparam int unsigned DW = 10;
    localparam int unsigned AW = 20;
    localparam int unsigned CW = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [DW-1:0]        a_in, b_in;
    logic                 a_valid_in, b_valid_in, clr_in, load_in;
    logic [AW-1:0]        drain_in;
    logic                 drain_valid_in;

    logic signed [DW-1:0] sat_a_out, sat_b_out, wrp_a_out, wrp_b_out;
    logic                 sat_av, sat_bv, sat_clr, wrp_av, wrp_bv, wrp_clr;
    logic signed [AW-1:0] sat_drain, sat_acc, wrp_drain, wrp_acc;
    logic                 sat_dv, sat_ovf, wrp_dv, wrp_ovf;
    logic [CW-1:0]        sat_cnt, wrp_cnt;
    logic [1:0]           sat_st, wrp_st;

    int n_cmp  = 0;
    int n_fail = 0;
    int proto_err = 0;

    always #5 clk = ~clk;

    pe_os_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1'b1), .CNT_WIDTH(CW)) u_sat (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .clr_in(clr_in), .load_in(load_in), .drain_in(drain_in),
        .drain_valid_in(drain_valid_in),
        .a_out(sat_a_out), .a_valid_out(sat_av), .b_out(sat_b_out), .b_valid_out(sat_bv),
        .clr_out(sat_clr), .drain_out(sat_drain), .drain_valid_out(sat_dv),
        .acc_out(sat_acc), .ovf(sat_ovf), .mac_cnt(sat_cnt), .state(sat_st)
    );

    pe_os_acc #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .SATURATE(1'b0), .CNT_WIDTH(CW)) u_wrp (
        .clk(clk), .rst(rst),
        .a_in(a_in), .a_valid_in(a_valid_in), .b_in(b_in), .b_valid_in(b_valid_in),
        .clr_in(clr_in), .load_in(load_in), .drain_in(drain_in),
        .drain_valid_in(drain_valid_in),
        .a_out(wrp_a_out), .a_valid_out(wrp_av), .b_out(wrp_b_out), .b_valid_out(wrp_bv),
        .clr_out(wrp_clr), .drain_out(wrp_drain), .drain_valid_out(wrp_dv),
        .acc_out(wrp_acc), .ovf(wrp_ovf), .mac_cnt(wrp_cnt), .state(wrp_st)
    );

    // Load colliding with valid upstream drain data is a controller error.
    always @(posedge clk) begin
        if (rst && load_in && drain_valid_in) proto_err <= proto_err + 1;
    end

    task automatic check_eq(input string tag, input logic signed [31:0] got,
                            input logic signed [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic drive(input int a, input bit av, input int b, input bit bv,
                         input bit clr, input bit load, input int din, input bit dv);
        a_in           = DW'(a);
        a_valid_in     = av;
        b_in           = DW'(b);
        b_valid_in     = bv;
        clr_in         = clr;
        load_in        = load;
        drain_in       = AW'(din);
        drain_valid_in = dv;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every input active.
        rst = 1'b0;
        drive(5, 1, 6, 1, 1, 1, 9, 1);
        step();
        step();
        check_eq("rst_a_out", sat_a_out, 0);
        check_eq("rst_a_v", {31'd0, sat_av}, 0);
        check_eq("rst_b_out", sat_b_out, 0);
        check_eq("rst_b_v", {31'd0, sat_bv}, 0);
        check_eq("rst_clr_out", {31'd0, sat_clr}, 0);
        check_eq("rst_drain", sat_drain, 0);
        check_eq("rst_drain_v", {31'd0, sat_dv}, 0);
        check_eq("rst_acc", sat_acc, 0);
        check_eq("rst_ovf", {31'd0, sat_ovf}, 0);
        check_eq("rst_cnt", {24'd0, sat_cnt}, 0);
        check_eq("rst_state", {30'd0, sat_st}, 0);

        // Release: outputs follow inputs one cycle later.
        rst = 1'b1;
        drive(5, 1, 6, 0, 1, 0, 9, 1);
        step();
        check_eq("rel_a_out", sat_a_out, 5);
        check_eq("rel_a_v", {31'd0, sat_av}, 1);
        check_eq("rel_b_out", sat_b_out, 6);
        check_eq("rel_b_v", {31'd0, sat_bv}, 0);
        check_eq("rel_clr_out", {31'd0, sat_clr}, 1);
        check_eq("rel_drain", sat_drain, 9);
        check_eq("rel_drain_v", {31'd0, sat_dv}, 1);
        check_eq("rel_acc", sat_acc, 0);

        // Basic MAC: 3*4=12, -5*6=-30 -> -18, 7*-2=-14 -> -32.
        drive(3, 1, 4, 1, 1, 0, 0, 0);
        step();
        check_eq("mac1_acc", sat_acc, 12);
        check_eq("mac1_cnt", {24'd0, sat_cnt}, 1);
        check_eq("mac1_state", {30'd0, sat_st}, 1);
        check_eq("mac1_a_out", sat_a_out, 3);
        drive(-5, 1, 6, 1, 0, 0, 0, 0);
        step();
        check_eq("mac2_acc", sat_acc, -18);
        check_eq("mac2_a_out", sat_a_out, -5);
        check_eq("mac2_clr_out", {31'd0, sat_clr}, 0);
        drive(7, 1, -2, 1, 0, 0, 0, 0);
        step();
        check_eq("mac3_acc", sat_acc, -32);
        check_eq("mac3_wrp_acc", wrp_acc, -32);
        check_eq("mac3_cnt", {24'd0, sat_cnt}, 3);
        check_eq("mac3_state", {30'd0, sat_st}, 1);
        check_eq("mac3_b_out", sat_b_out, -2);

        // Valid gating: only a valid.
        drive(100, 1, 100, 0, 0, 0, 0, 0);
        repeat (3) step();
        check_eq("gate_acc", sat_acc, -32);
        check_eq("gate_cnt", {24'd0, sat_cnt}, 3);
        check_eq("gate_a_v", {31'd0, sat_av}, 1);
        check_eq("gate_a_out", sat_a_out, 100);
        check_eq("gate_b_v", {31'd0, sat_bv}, 0);
        drive(100, 0, 100, 0, 0, 0, 0, 0);
        step();
        check_eq("gate_a_v_fall", {31'd0, sat_av}, 0);

        // Drain: acc=42, load, then shift upstream data through.
        drive(6, 1, 7, 1, 1, 0, 0, 0);
        step();
        check_eq("drn_acc", sat_acc, 42);
        drive(0, 0, 0, 0, 0, 1, 0, 0);
        step();
        check_eq("drn_load", sat_drain, 42);
        check_eq("drn_load_v", {31'd0, sat_dv}, 1);
        check_eq("drn_state", {30'd0, sat_st}, 2);
        check_eq("drn_acc_hold", sat_acc, 42);
        drive(0, 0, 0, 0, 0, 0, 7, 1);
        step();
        check_eq("drn_shift", sat_drain, 7);
        check_eq("drn_shift_v", {31'd0, sat_dv}, 1);
        check_eq("drn_state_hold", {30'd0, sat_st}, 2);
        // DONE + fire without clear resumes accumulation.
        drive(1, 1, 1, 1, 0, 0, 0, 0);
        step();
        check_eq("done_resume_acc", sat_acc, 43);
        check_eq("done_resume_st", {30'd0, sat_st}, 1);
        check_eq("drn_v_fall", {31'd0, sat_dv}, 0);

        // Simultaneous clear + fire + load with acc=50.
        drive(5, 1, 10, 1, 1, 0, 0, 0);
        step();
        check_eq("sim_pre_acc", sat_acc, 50);
        drive(2, 1, 2, 1, 1, 1, 0, 0);
        step();
        check_eq("sim_drain", sat_drain, 50);
        check_eq("sim_drain_v", {31'd0, sat_dv}, 1);
        check_eq("sim_acc", sat_acc, 4);
        check_eq("sim_cnt", {24'd0, sat_cnt}, 1);
        check_eq("sim_state", {30'd0, sat_st}, 1);

        // Positive overflow: 262144 + 262144 exceeds 524287.
        drive(-512, 1, -512, 1, 1, 0, 0, 0);
        step();
        check_eq("psat1_acc", sat_acc, 262144);
        check_eq("psat1_ovf", {31'd0, sat_ovf}, 0);
        drive(-512, 1, -512, 1, 0, 0, 0, 0);
        step();
        check_eq("psat2_sat_acc", sat_acc, 524287);
        check_eq("psat2_sat_ovf", {31'd0, sat_ovf}, 1);
        check_eq("psat2_wrp_acc", wrp_acc, -524288);
        check_eq("psat2_wrp_ovf", {31'd0, wrp_ovf}, 1);
        drive(0, 0, 0, 0, 1, 0, 0, 0);
        step();
        check_eq("clr_ovf", {31'd0, sat_ovf}, 0);
        check_eq("clr_wrp_ovf", {31'd0, wrp_ovf}, 0);
        check_eq("clr_acc", sat_acc, 0);
        check_eq("clr_cnt", {24'd0, sat_cnt}, 0);
        check_eq("clr_state", {30'd0, sat_st}, 0);

        // Negative overflow: 3 * -261632 = -784896 < -524288.
        drive(-512, 1, 511, 1, 1, 0, 0, 0);
        step();
        drive(-512, 1, 511, 1, 0, 0, 0, 0);
        step();
        check_eq("nsat2_acc", sat_acc, -523264);
        check_eq("nsat2_ovf", {31'd0, sat_ovf}, 0);
        step();
        check_eq("nsat3_sat_acc", sat_acc, -524288);
        check_eq("nsat3_wrp_acc", wrp_acc, 263680);
        check_eq("nsat3_ovf", {31'd0, sat_ovf}, 1);
        drive(1, 1, 1, 1, 0, 0, 0, 0);
        step();
        check_eq("sticky_acc", sat_acc, -524287);
        check_eq("sticky_ovf", {31'd0, sat_ovf}, 1);

        // MAC counter saturates at all-ones.
        drive(0, 1, 0, 1, 1, 0, 0, 0);
        step();
        drive(0, 1, 0, 1, 0, 0, 0, 0);
        repeat (260) step();
        check_eq("cnt_sat", {24'd0, sat_cnt}, 255);
        check_eq("cnt_sat_acc", sat_acc, 0);

        // Reset mid-tile overrides fire and load.
        drive(3, 1, 3, 1, 0, 1, 0, 0);
        rst = 1'b0;
        step();
        check_eq("rst_mid_acc", sat_acc, 0);
        check_eq("rst_mid_cnt", {24'd0, sat_cnt}, 0);
        check_eq("rst_mid_drain_v", {31'd0, sat_dv}, 0);
        check_eq("rst_mid_state", {30'd0, sat_st}, 0);
        check_eq("rst_mid_a_v", {31'd0, sat_av}, 0);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        check_eq("protocol", proto_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pe_os_acc.md
Name: pe_os_acc

Overview:
Next-generation output-stationary systolic-array processing element.
- Multiply-accumulates a signed row operand (a) and column operand (b) when both are valid.
- Forwards both operands, with their valid flags, to neighbours one cycle later.
- Exposes its accumulator through a vertical drain shift chain, so a tile's results can be unloaded while the next tile accumulates.
- Adds over the earlier PE: valid gating, tile clear, configurable accumulator width, saturation, overflow flag, MAC counter and a small tile FSM.

Parameters:
- DATA_WIDTH, 10, signed operand width.
- ACC_WIDTH, 2*DATA_WIDTH+4, signed accumulator width; must be >= 2*DATA_WIDTH.
- SATURATE, 1, 1 = clamp accumulator on overflow; 0 = two's-complement wrap.
- CNT_WIDTH, 8, MAC counter width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous active-low reset.
- a_in  in  DATA_WIDTH  signed row operand.
- a_valid_in  in  1  a_in valid.
- b_in  in  DATA_WIDTH  signed column operand.
- b_valid_in  in  1  b_in valid.
- clr_in  in  1  start of new tile; travels with a.
- load_in  in  1  capture accumulator into drain register.
- drain_in  in  ACC_WIDTH  drain data from upstream PE.
- drain_valid_in  in  1  drain_in valid.
- a_out  out  DATA_WIDTH  registered a_in.
- a_valid_out  out  1  registered a_valid_in.
- b_out  out  DATA_WIDTH  registered b_in.
- b_valid_out  out  1  registered b_valid_in.
- clr_out  out  1  registered clr_in.
- drain_out  out  ACC_WIDTH  drain register.
- drain_valid_out  out  1  drain register valid.
- acc_out  out  ACC_WIDTH  live accumulator.
- ovf  out  1  sticky overflow since last clear.
- mac_cnt  out  CNT_WIDTH  MACs since last clear, saturating at all-ones.
- state  out  2  FSM state: IDLE=0, ACCUM=1, DONE=2.

Behaviour:
- Reset (rst=0 at a clk edge) zeroes every output and register; state=IDLE. Reset overrides all inputs, including mid-tile and mid-drain.
- Forwarding: a/b/valids/clr_out equal the previous-cycle inputs (latency 1, unconditional). No combinational input-to-output paths.
- fire = a_valid_in & b_valid_in.
- Product: full-precision signed DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH, sign-extended to ACC_WIDTH.
- Sum: compute in ACC_WIDTH+1 bits. Overflow occurs when the result is outside the ACC_WIDTH range.
  - SATURATE=1: clamp to max/min.
  - SATURATE=0: keep the low ACC_WIDTH bits.
  - Either mode sets ovf (sticky).
- clr_in & fire: acc<=product; ovf<=overflow of the product alone (never, given the width rule); mac_cnt<=1; state<=ACCUM.
- clr_in & !fire: acc<=0; ovf<=0; mac_cnt<=0; state<=IDLE.
- !clr_in & fire: acc<=acc+product; mac_cnt++ (saturating); state<=ACCUM.
- !clr_in & !fire: hold acc, ovf, mac_cnt and state.
- load_in: drain_out<=acc value before this cycle's update; drain_valid_out<=1. From ACCUM or IDLE, state<=DONE, unless clr_in or fire in the same cycle, which take the transition above.
- DONE holds acc. Next fire without clr returns to ACCUM and keeps accumulating. clr returns to IDLE.
- !load_in: drain_out<=drain_in; drain_valid_out<=drain_valid_in (one shift per cycle, latency 1 per PE).
- load_in & drain_valid_in same cycle: load wins and upstream drain data is dropped. The controller must avoid this; the bench flags it as a protocol error.
- acc_out is the registered accumulator.

Test Plan:
- Reset: drive all inputs nonzero with rst=0 for 2 cycles -> all outputs 0, state=0; release -> outputs follow inputs after 1 cycle.
- Basic MAC: clr with (a=3, b=4), then (a=-5, b=6) and (a=7, b=-2), all valid -> acc_out: 12, -18, -32; mac_cnt 3; state=ACCUM; a_out/b_out lag by 1 cycle.
- Valid gating: a_valid=1, b_valid=0 for 3 cycles with a=100, b=100 -> acc unchanged, mac_cnt unchanged; a_valid_out pulses with a_out=100.
- Saturation: ACC_WIDTH=20, SATURATE=1, clr, then two fires of a=-512, b=-512 -> acc 262144 then 524287, ovf=1. With SATURATE=0 -> -524288, ovf=1. Next clr -> ovf=0.
- Drain: acc=42 with load_in=1 -> next cycle drain_out=42, drain_valid_out=1, state=DONE. Then feed drain_in=7 valid -> drain_out=7 one cycle later.
- Simultaneous: clr_in+fire (a=2, b=2)+load_in with acc=50 -> drain_out=50; acc=4; mac_cnt=1; state=ACCUM.
